// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared helpers for the KxK window generator
package conv_pkg;

   // Bits needed to index v entries (never less than 1)
   function automatic int clog2(input int v);
      int r;
      r = 1;
      for (int i = 1; i < 32; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

   // Bit offset of tap (r,c) of channel ch inside the packed window bus
   function automatic int tap_off(input int ch, input int r, input int c,
                                  input int k, input int n);
      return ((ch * k * k) + (r * k) + c) * n;
   endfunction

   // Bit offset of channel ch inside a packed pixel bus
   function automatic int ch_off(input int ch, input int n);
      return ch * n;
   endfunction

   // Kernel sizes the compute element understands
   function automatic bit kernel_ok(input int k);
      return (k == 1) || (k == 3) || (k == 5) || (k == 7);
   endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// rtl/conv_line_buffer.sv - one image row of delay for all channels
module conv_line_buffer
   import conv_pkg::*;
#(
   parameter int DEPTH = 28,
   parameter int WIDTH = 16
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             i_en,
   input  logic [WIDTH-1:0] i_din,
   output logic [WIDTH-1:0] o_dout
);

   localparam int AW = clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_ptr;

   // The slot about to be overwritten holds the pixel from exactly one row ago
   assign o_dout = r_mem[r_ptr];

   // Storage is left unreset; row qualification upstream hides stale data
   always_ff @(posedge clk) begin
      if (i_en) r_mem[r_ptr] <= i_din;
   end

   // Circular pointer advances once per accepted pixel
   always_ff @(posedge clk or posedge rst) begin
      if (rst)       r_ptr <= '0;
      else if (i_en) r_ptr <= (r_ptr == AW'(DEPTH - 1)) ? '0 : r_ptr + 1'b1;
   end

endmodule

// File: rtl/conv_window_gen.sv
// rtl/conv_window_gen.sv - streaming KxK window generator; CONV_WIN_STRIDE2_EN selects stride 2
module conv_window_gen
   import conv_pkg::*;
#(
   parameter int CL_IN  = 2,
   parameter int KERNEL = 3,
   parameter int N      = 8,
   parameter int IMG_W  = 28,
   parameter int IMG_H  = 28
)
(
   input  logic                             clk,
   input  logic                             rst,
   input  logic [CL_IN*N-1:0]               pix_in,
   input  logic                             pix_valid,
   input  logic                             sof,
   output logic [CL_IN*KERNEL*KERNEL*N-1:0] data2conv,
   output logic                             en_out,
   output logic                             frame_done
);

   localparam int PW = CL_IN * N;
   localparam int WW = CL_IN * KERNEL * KERNEL * N;
   localparam int CW = clog2(IMG_W);
   localparam int RW = clog2(IMG_H);

   generate
      if (!kernel_ok(KERNEL)) begin : g_bad_kernel
         $error("conv_window_gen: KERNEL must be 1, 3, 5 or 7");
      end
   endgenerate

   logic [CW-1:0] r_col;
   logic [RW-1:0] r_row;
   logic [CW-1:0] w_col;
   logic [RW-1:0] w_row;
   logic [PW-1:0] w_chain [KERNEL];
   logic [WW-1:0] r_win;
   logic [WW-1:0] w_win_next;
   logic          w_stride_ok;
   logic          w_hit;
   logic          w_last;

   // w_chain[j] is the pixel j rows above the incoming one
   assign w_chain[0] = pix_in;
   generate
      for (genvar j = 0; j < KERNEL - 1; j++) begin : g_lb
         conv_line_buffer #(.DEPTH(IMG_W), .WIDTH(PW)) u_lb (
            .clk    (clk),
            .rst    (rst),
            .i_en   (pix_valid),
            .i_din  (w_chain[j]),
            .o_dout (w_chain[j+1])
         );
      end
   endgenerate

   // sof relabels the pixel being accepted as (0,0)
   assign w_col = sof ? '0 : r_col;
   assign w_row = sof ? '0 : r_row;

`ifdef CONV_WIN_STRIDE2_EN
   logic [CW-1:0] w_col_off;
   logic [RW-1:0] w_row_off;
   assign w_col_off   = w_col - CW'(KERNEL - 1);
   assign w_row_off   = w_row - RW'(KERNEL - 1);
   assign w_stride_ok = ~w_col_off[0] & ~w_row_off[0];
`else
   assign w_stride_ok = 1'b1;
`endif

   // A window is complete once K rows and K columns of this frame are in
   assign w_hit  = pix_valid & (w_row >= RW'(KERNEL - 1)) & (w_col >= CW'(KERNEL - 1)) & w_stride_ok;
   assign w_last = pix_valid & (w_row == RW'(IMG_H - 1)) & (w_col == CW'(IMG_W - 1));

   // Shift every row of the window left by one column and append the new column
   always_comb begin
      w_win_next = r_win;
      for (int ch = 0; ch < CL_IN; ch++) begin
         for (int r = 0; r < KERNEL; r++) begin
            for (int c = 0; c < KERNEL; c++) begin
               if (c == KERNEL - 1)
                  w_win_next[tap_off(ch, r, c, KERNEL, N) +: N] = w_chain[KERNEL-1-r][ch_off(ch, N) +: N];
               else
                  w_win_next[tap_off(ch, r, c, KERNEL, N) +: N] = r_win[tap_off(ch, r, c + 1, KERNEL, N) +: N];
            end
         end
      end
   end

   // Raster position of the next pixel to be accepted
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_col <= '0;
         r_row <= '0;
      end else if (pix_valid) begin
         if (w_col == CW'(IMG_W - 1)) begin
            r_col <= '0;
            r_row <= (w_row == RW'(IMG_H - 1)) ? '0 : w_row + 1'b1;
         end else begin
            r_col <= w_col + 1'b1;
            r_row <= w_row;
         end
      end
   end

   // Window shift register and registered outputs; data2conv holds between strobes
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_win      <= '0;
         data2conv  <= '0;
         en_out     <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         en_out     <= w_hit;
         frame_done <= w_last;
         if (pix_valid) r_win     <= w_win_next;
         if (w_hit)     data2conv <= w_win_next;
      end
   end

endmodule

// File: doc/conv_window_gen.md
# conv_window_gen

Streaming KxK window generator that feeds the convolution compute element. Accepts one pixel per valid cycle for all CL_IN input channels in raster order and buffers K-1 image rows per channel. Emits a fully packed `data2conv` vector with a one-cycle `en_out` strobe for every valid (unpadded) convolution position. Its output bus plugs directly into the CE `data2conv`/`en_in` pair.

## Interface
- `CL_IN`, 2, number of input channels (1..256)
- `KERNEL`, 3, window size (1/3/5/7)
- `N`, 8, pixel width per channel
- `IMG_W`, 28, image width in pixels (>= KERNEL)
- `IMG_H`, 28, image height in pixels (>= KERNEL)
- `clk` in 1: single clock, all logic on posedge
- `rst` in 1: asynchronous, active-high reset
- `pix_in` in CL_IN*N: one pixel of every channel; channel i at `[i*N +: N]`
- `pix_valid` in 1: `pix_in` is accepted this cycle
- `sof` in 1: qualified by `pix_valid`; marks the accepted pixel as row 0, col 0
- `data2conv` out CL_IN*KERNEL*KERNEL*N: packed window
- `en_out` out 1: one-cycle strobe; `data2conv` is valid this cycle
- `frame_done` out 1: one-cycle strobe coincident with the last window of a frame

## Operation
- No backpressure. The downstream CE always accepts. `pix_valid` gaps of any length are allowed, and all state holds during gaps.
- Counters `col` (0..IMG_W-1) and `row` (0..IMG_H-1) advance on each accepted pixel. `col` wraps to 0 and increments `row`. After (IMG_H-1, IMG_W-1), both wrap to 0.
- `sof` with `pix_valid` forces the accepted pixel to (0,0), and counting continues from there. This also applies mid-frame. Any partial frame is abandoned without `frame_done`.
- Per channel: K-1 circular line buffers of IMG_W x N bits, plus a KxK window shift register. Line buffer RAM is not reset. Stale contents are masked by the row/col qualification.
- Window valid when the accepted pixel has `row >= K-1` and `col >= K-1`. Windows never straddle rows.
- Packing: channel i at `[i*K*K*N +: K*K*N]`. Within a channel, tap `r*K+c` is at `[(r*K+c)*N +: N]`. Row r=0 is the oldest row (top) and c=0 the oldest column (left). Tap K*K-1 is the just-accepted pixel.
- KERNEL==1: no line buffers. Every accepted pixel produces a window.
- Windows per frame: (IMG_H-K+1)*(IMG_W-K+1).
- `frame_done` asserts with the `en_out` produced by pixel (IMG_H-1, IMG_W-1).

## Timing
- Reset values: `en_out`=0, `frame_done`=0, `data2conv`=0, counters=0, window registers=0.
- Latency: `en_out` rises exactly 1 cycle after the posedge that accepts the window-completing pixel.
- `data2conv` is registered. It holds its last value while `en_out` is low.
- Maximum output rate is one window per clock, sustained with back-to-back `pix_valid`.
- `rst` asserted mid-frame clears outputs immediately (asynchronously). The first pixel after reset release is treated as (0,0) whether or not `sof` is set.
- `sof` on the same pixel that would complete a window: `sof` wins, and no `en_out` is generated for that pixel.

## Configuration
- Macro `CONV_WIN_STRIDE2_EN`.
  - Defined: stride 2. A window is emitted only when (row-(K-1)) and (col-(K-1)) are both even. Windows per frame = ceil((IMG_H-K+1)/2) * ceil((IMG_W-K+1)/2). `frame_done` accompanies the last emitted window, or, if (IMG_H-1, IMG_W-1) is not a stride position, pulses alone 1 cycle after that pixel is accepted.
  - Undefined: stride 1, as described above.

## Structure
- Shared package `conv_pkg`: `clog2` function, tap/channel slice-offset constants, and the KERNEL legality check.
- Sub-module `conv_line_buffer`: one IMG_W-deep, CL_IN*N-wide circular delay line, written and read on `pix_valid`. It is instantiated K-1 times in a cascade.
- Top level: counters, window shift registers, qualification, and output registers.

## Test plan
Defaults for all scenarios except where noted: CL_IN=2, K=3, N=8, IMG_W=IMG_H=5. Pixel ch0 = row*16+col; ch1 = 0x80|ch0.
1. Full frame, continuous `pix_valid`, `sof` on the first pixel -> 9 `en_out` strobes.
   - First strobe 1 cycle after pixel (2,2): ch0 taps 0..8 = 00,01,02,10,11,12,20,21,22; ch1 taps = 80..A2.
   - `frame_done` with the 9th strobe, whose ch0 tap8 = 0x44.
2. Same frame with a 1-cycle gap after every pixel -> identical 9 windows and values; `en_out` never asserts during a gap.
3. Two back-to-back frames -> 18 strobes. The second frame's first window equals the first frame's (no stale rows leak), and `frame_done` pulses twice.
4. `sof` reasserted at pixel (3,1) of frame 1 -> no `frame_done` for frame 1; the restarted frame yields exactly 9 windows with correct values.
5. `rst` pulsed at pixel (2,3) -> all outputs 0 immediately. A following full frame yields exactly 9 correct windows.
6. `CONV_WIN_STRIDE2_EN`, IMG_W=IMG_H=6 -> 4 windows, at pixels (2,2),(2,4),(4,2),(4,4). `frame_done` pulses alone 1 cycle after pixel (5,5).
